// File: rtl/uart_pkg.sv
// Shared constants for the uart RX FIFO block: master FSM encoding,
// default addresses and the bit layout of the DATA and STAT words.
package uart_pkg;

  localparam logic [31:0] UART_ADR_DEF    = 32'h0000_00FF;
  localparam logic [31:0] DATA_ADR_DEF    = 32'h0000_0100;
  localparam logic [31:0] STAT_ADR_DEF    = 32'h0000_0101;
  localparam int unsigned DEPTH_LOG2_DEF  = 4;
  localparam logic [3:0]  ACK_TIMEOUT_DEF = 4'd15;

  // One-hot master FSM states
  localparam int unsigned M_STATE_W = 3;
  localparam logic [M_STATE_W-1:0] M_IDLE = 3'b001;
  localparam logic [M_STATE_W-1:0] M_READ = 3'b010;
  localparam logic [M_STATE_W-1:0] M_GAP  = 3'b100;

  // STAT word bit positions
  localparam int unsigned STAT_EMPTY     = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVF       = 2;
  localparam int unsigned STAT_ERR       = 3;
  localparam int unsigned STAT_COUNT_LSB = 8;

  // DATA word valid flag position
  localparam int unsigned DATA_VALID = 8;

  // DATA word for a valid head byte
  function automatic logic [31:0] data_word(input logic [7:0] b);
    logic [31:0] w;
    w             = '0;
    w[DATA_VALID] = 1'b1;
    w[7:0]        = b;
    return w;
  endfunction

  // STAT word assembled from FIFO/flag state
  function automatic logic [31:0] stat_word(input logic [7:0] cnt, input logic err,
                                            input logic ovf, input logic full,
                                            input logic empty);
    logic [31:0] w;
    w                                       = '0;
    w[STAT_COUNT_LSB+7:STAT_COUNT_LSB]      = cnt;
    w[STAT_ERR]                             = err;
    w[STAT_OVF]                             = ovf;
    w[STAT_FULL]                            = full;
    w[STAT_EMPTY]                           = empty;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Wishbone classic bus bundle; master drives the request, slave answers.
interface uart_rx_fifo_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        we;
  logic        stb;
  logic        cyc;
  logic [3:0]  sel;
  logic        ack;

  modport master (output adr, wdat, we, stb, cyc, sel, input rdat, ack);
  modport slave  (input adr, wdat, we, stb, cyc, sel, output rdat, ack);
endinterface

// File: rtl/sync_fifo_8.sv
// Byte FIFO with count; push accepted when not full or when popping in
// the same cycle, flush overrides everything.
module sync_fifo_8 #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty,
  output logic                full
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_pop;
  logic                  do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; no reset needed on the array
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Drains received bytes from the upstream uart into a FIFO and exposes
// the FIFO to the CPU through DATA (pop) and STAT (status/flush) registers.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter logic [31:0] UART_ADR    = UART_ADR_DEF,
  parameter logic [31:0] DATA_ADR    = DATA_ADR_DEF,
  parameter logic [31:0] STAT_ADR    = STAT_ADR_DEF,
  parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter logic [3:0]  ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  clk_48_i,
  input  logic                  rst_i,
  uart_rx_fifo_if.slave         cpu,
  uart_rx_fifo_if.master        uart,
  input  logic                  uart_irq_i,
  output logic                  irq_o
);

  logic [M_STATE_W-1:0] m_state;
  logic [3:0]           timer;
  logic                 m_cyc;
  logic                 ovf;
  logic                 err;
  logic                 ack_q;
  logic [31:0]          dat_q;

  logic                 hit_data;
  logic                 hit_stat;
  logic                 req;
  logic                 rd_data;
  logic                 rd_stat;
  logic                 flush;
  logic                 push;
  logic                 pop;
  logic                 ovf_set;
  logic                 err_set;

  logic [7:0]           head;
  logic [DEPTH_LOG2:0]  count;
  logic                 empty;
  logic                 full;
  logic                 unused;

  assign unused = ^{cpu.sel, cpu.wdat[31:1], uart.rdat[31:8]};

  // Slave request decode
  assign hit_data = (cpu.adr == DATA_ADR);
  assign hit_stat = (cpu.adr == STAT_ADR);
  assign req      = cpu.cyc & cpu.stb & (hit_data | hit_stat) & ~ack_q;
  assign rd_data  = req & ~cpu.we & hit_data;
  assign rd_stat  = req & ~cpu.we & hit_stat;
  assign flush    = req & cpu.we & hit_stat & cpu.wdat[0];
  assign pop      = rd_data & ~empty;

  // Master-side push and flag set conditions
  assign push    = (m_state == M_READ) & uart.ack;
  assign ovf_set = push & full & ~pop & ~flush;
  assign err_set = (m_state == M_READ) & ~uart.ack & (timer == 4'd0);

  sync_fifo_8 #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk_48_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (uart.rdat[7:0]),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Master FSM: one bounded read per irq, then a gap cycle so irq can clear
  always_ff @(posedge clk_48_i) begin
    if (rst_i) begin
      m_state <= M_IDLE;
      m_cyc   <= 1'b0;
      timer   <= 4'd0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (uart_irq_i) begin
            m_state <= M_READ;
            m_cyc   <= 1'b1;
            timer   <= ACK_TIMEOUT;
          end
        end
        M_READ: begin
          if (uart.ack || timer == 4'd0) begin
            m_state <= M_GAP;
            m_cyc   <= 1'b0;
          end else begin
            timer <= timer - 4'd1;
          end
        end
        M_GAP: begin
          m_state <= M_IDLE;
        end
        default: begin
          m_state <= M_IDLE;
          m_cyc   <= 1'b0;
        end
      endcase
    end
  end

  assign uart.cyc  = m_cyc;
  assign uart.stb  = m_cyc;
  assign uart.adr  = UART_ADR;
  assign uart.wdat = 32'h0;
  assign uart.we   = 1'b0;
  assign uart.sel  = 4'hF;

  // Slave response, read data and sticky flags (set beats status-read clear)
  always_ff @(posedge clk_48_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 32'h0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      ack_q <= req;
      if (rd_data) dat_q <= empty ? 32'h0 : data_word(head);
      if (rd_stat) dat_q <= stat_word(8'(count), err, ovf, full, empty);
      ovf <= ovf_set | (ovf & ~rd_stat);
      err <= err_set | (err & ~rd_stat);
    end
  end

  assign cpu.ack  = ack_q;
  assign cpu.rdat = dat_q;
  assign irq_o    = (count != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table for basic register behaviour,
// scoreboard queue for FIFO contents, hand sequences for corner cases.
module tb_uart_rx_fifo;

  localparam logic [31:0] UART_ADR = 32'h0000_00FF;
  localparam logic [31:0] DATA_ADR = 32'h0000_0100;
  localparam logic [31:0] STAT_ADR = 32'h0000_0101;
  localparam int          DEPTH    = 16;

  logic clk_48_i;
  logic rst_i;
  logic uart_irq_i;
  logic irq_o;

  uart_rx_fifo_if cpu();
  uart_rx_fifo_if uart();

  uart_rx_fifo dut (
    .clk_48_i   (clk_48_i),
    .rst_i      (rst_i),
    .cpu        (cpu),
    .uart       (uart),
    .uart_irq_i (uart_irq_i),
    .irq_o      (irq_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard state
  logic [7:0] sb[$];
  logic       sb_ovf = 1'b0;
  logic       sb_err = 1'b0;

  // Uart model controls
  logic       manual    = 1'b0;
  int         ack_delay = 2;
  logic [7:0] model_byte = 8'h00;

  initial clk_48_i = 1'b0;
  always #10 clk_48_i = ~clk_48_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Uart CSR model: acks ack_delay cycles after the strobe appears
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk_48_i);
      if (!manual) begin
        uart.ack = 1'b0;
        if (uart.cyc && uart.stb) begin
          wcnt++;
          if (wcnt >= ack_delay) begin
            uart.ack  = 1'b1;
            uart.rdat = {24'hABCDEF, model_byte};
            wcnt      = 0;
            check("m_adr", uart.adr, UART_ADR);
            check("m_we", 32'(uart.we), 32'h0);
          end
        end else begin
          wcnt = 0;
        end
      end
    end
  end

  task automatic cpu_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] r, output logic got);
    @(negedge clk_48_i);
    cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.we = w; cpu.adr = a; cpu.wdat = d;
    got = 1'b0;
    r   = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_48_i);
      if (cpu.ack) begin
        got = 1'b1;
        r   = cpu.rdat;
        break;
      end
    end
    cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] r;
    logic        g;
    cpu_access(1'b0, a, 32'h0, r, g);
    check({name, "_ack"}, 32'(g), 32'h1);
    check(name, r, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] hold,
                    input string name);
    logic [31:0] r;
    logic        g;
    cpu_access(1'b1, a, d, r, g);
    check({name, "_ack"}, 32'(g), 32'h1);
    check({name, "_hold"}, r, hold);
  endtask

  // One irq-triggered read through the auto-acking model
  task automatic uart_push(input logic [7:0] b);
    logic started;
    logic done;
    started = 1'b0;
    done    = 1'b0;
    @(negedge clk_48_i);
    uart_irq_i = 1'b1;
    model_byte = b;
    @(negedge clk_48_i);
    uart_irq_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (uart.cyc) started = 1'b1;
      else if (started) begin
        done = 1'b1;
        break;
      end
      @(negedge clk_48_i);
    end
    if (!done) check("push_timeout", 32'(done), 32'h1);
    @(negedge clk_48_i);
  endtask

  task automatic sb_push(input logic [7:0] b);
    uart_push(b);
    if (sb.size() < DEPTH) sb.push_back(b);
    else sb_ovf = 1'b1;
  endtask

  function automatic logic [31:0] stat_exp();
    return {16'h0, 8'(sb.size()), 4'h0, sb_err, sb_ovf,
            (sb.size() == DEPTH), (sb.size() == 0)};
  endfunction

  task automatic rd_stat_sb(input string name);
    rd(STAT_ADR, stat_exp(), name);
    sb_ovf = 1'b0;
    sb_err = 1'b0;
  endtask

  task automatic rd_data_sb(input string name);
    logic [31:0] e;
    e = 32'h0;
    if (sb.size() > 0) e = {23'h0, 1'b1, sb.pop_front()};
    rd(DATA_ADR, e, name);
  endtask

  // Raise irq with the model silent; returns at a negedge with cyc asserted
  task automatic start_manual_read();
    manual   = 1'b1;
    uart.ack = 1'b0;
    @(negedge clk_48_i);
    uart_irq_i = 1'b1;
    @(negedge clk_48_i);
    uart_irq_i = 1'b0;
    for (int i = 0; i < 4 && !uart.cyc; i++) @(negedge clk_48_i);
    check("manual_cyc", 32'(uart.cyc), 32'h1);
  endtask

  typedef enum int {OP_RD, OP_WR, OP_PUSH} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] adr;
    logic [31:0] arg;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        g;
    int          cnt;

    rst_i = 1'b1; uart_irq_i = 1'b0;
    cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0; cpu.adr = 32'h0;
    cpu.wdat = 32'h0; cpu.sel = 4'hF;
    uart.ack = 1'b0; uart.rdat = 32'h0;

    // Register-level vectors: {op, address, write data / pushed byte, expected}
    vecs[0]  = '{OP_RD,   STAT_ADR, 32'h0,  32'h0000_0001};
    vecs[1]  = '{OP_RD,   DATA_ADR, 32'h0,  32'h0000_0000};
    vecs[2]  = '{OP_PUSH, 32'h0,    32'h41, 32'h1};
    vecs[3]  = '{OP_RD,   DATA_ADR, 32'h0,  32'h0000_0141};
    vecs[4]  = '{OP_RD,   STAT_ADR, 32'h0,  32'h0000_0001};
    vecs[5]  = '{OP_WR,   DATA_ADR, 32'hFF, 32'h0000_0001};
    vecs[6]  = '{OP_PUSH, 32'h0,    32'h5A, 32'h1};
    vecs[7]  = '{OP_PUSH, 32'h0,    32'hC3, 32'h1};
    vecs[8]  = '{OP_RD,   STAT_ADR, 32'h0,  32'h0000_0200};
    vecs[9]  = '{OP_WR,   STAT_ADR, 32'h0,  32'h0000_0200};
    vecs[10] = '{OP_RD,   DATA_ADR, 32'h0,  32'h0000_015A};
    vecs[11] = '{OP_RD,   DATA_ADR, 32'h0,  32'h0000_01C3};
    vecs[12] = '{OP_RD,   STAT_ADR, 32'h0,  32'h0000_0001};

    repeat (3) @(negedge clk_48_i);
    rst_i = 1'b0;
    @(negedge clk_48_i);
    check("rst_ack", 32'(cpu.ack), 32'h0);
    check("rst_dat", cpu.rdat, 32'h0);
    check("rst_mcyc", {30'h0, uart.cyc, uart.stb}, 32'h0);
    check("rst_madr", uart.adr, UART_ADR);
    check("rst_mdat", uart.wdat, 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);

    for (int i = 0; i < NV; i++) begin
      case (vecs[i].op)
        OP_RD:   rd(vecs[i].adr, vecs[i].exp, $sformatf("vec%0d", i));
        OP_WR:   wr(vecs[i].adr, vecs[i].arg, vecs[i].exp, $sformatf("vec%0d", i));
        default: begin
          uart_push(vecs[i].arg[7:0]);
          check($sformatf("vec%0d_irq", i), 32'(irq_o), vecs[i].exp);
        end
      endcase
    end

    // Unmatched address gets no ack
    cpu_access(1'b0, 32'h200, 32'h0, r, g);
    check("unmapped_ack", 32'(g), 32'h0);

    // Fill to full, overflow one byte, drain in order
    for (int i = 0; i < DEPTH; i++) sb_push(8'(i));
    sb_push(8'hAA);
    rd_stat_sb("ovf_stat");
    for (int i = 0; i < DEPTH; i++) rd_data_sb($sformatf("drain%0d", i));
    rd_stat_sb("ovf_clr_stat");
    check("drain_irq", 32'(irq_o), 32'h0);

    // Ack timeout: cyc stays up 16 cycles, err set then cleared by read
    manual = 1'b1;
    uart.ack = 1'b0;
    @(negedge clk_48_i);
    uart_irq_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_48_i);
      if (uart.cyc) cnt++;
      else if (cnt > 0) break;
    end
    uart_irq_i = 1'b0;
    check("timeout_cycles", 32'(cnt), 32'd16);
    sb_err = 1'b1;
    repeat (3) @(negedge clk_48_i);
    rd_stat_sb("err_stat");
    rd_stat_sb("err_clr_stat");
    manual = 1'b0;

    // Plain flush of 3 bytes
    for (int i = 0; i < 3; i++) sb_push(8'h10 + 8'(i));
    rd_stat_sb("pre_flush_stat");
    wr(STAT_ADR, 32'h1, 32'h0000_0300, "flush");
    sb.delete();
    check("flush_irq", 32'(irq_o), 32'h0);
    rd_stat_sb("flush_stat");

    // Flush with a same-cycle uart push: byte dropped, no overflow
    sb_push(8'h21);
    sb_push(8'h22);
    start_manual_read();
    uart.ack = 1'b1; uart.rdat = 32'h0000_0077;
    cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.we = 1'b1; cpu.adr = STAT_ADR; cpu.wdat = 32'h1;
    @(negedge clk_48_i);
    uart.ack = 1'b0;
    check("flushpush_ack", 32'(cpu.ack), 32'h1);
    check("flushpush_mcyc", 32'(uart.cyc), 32'h0);
    cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk_48_i);
    manual = 1'b0;
    check("flushpush_irq", 32'(irq_o), 32'h0);
    rd_stat_sb("flushpush_stat");

    // Full FIFO: push and pop in the same cycle both succeed
    for (int i = 0; i < DEPTH; i++) sb_push(8'h80 + 8'(i));
    start_manual_read();
    uart.ack = 1'b1; uart.rdat = 32'h1234_56EE;
    cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.we = 1'b0; cpu.adr = DATA_ADR;
    @(negedge clk_48_i);
    uart.ack = 1'b0;
    check("pushpop_ack", 32'(cpu.ack), 32'h1);
    check("pushpop_dat", cpu.rdat, {23'h0, 1'b1, sb.pop_front()});
    cpu.cyc = 1'b0; cpu.stb = 1'b0;
    sb.push_back(8'hEE);
    repeat (2) @(negedge clk_48_i);
    manual = 1'b0;
    rd_stat_sb("pushpop_stat");
    for (int i = 0; i < DEPTH; i++) rd_data_sb($sformatf("pp_drain%0d", i));
    rd_stat_sb("pp_final_stat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
